line_mem_initiator: RTL and testbench
=====================================

Name: line_mem_initiator

Overview:
- Initiator side of the word-level cache/memory request interface (cache_to_mem_type / mem_to_cache_type).
- Converts one cache-line request (fill or writeback) from the cache FSM into WORDS_PER_LINE sequential 16-bit word transactions to the SRAM controller.
- Collects read words into a line buffer and signals completion with a single-cycle pulse.
- Sits between the cache FSM and sram_controller; the cache FSM never handles per-word handshakes.

Parameters:
- WORDS_PER_LINE, 8, words per cache line; power of two, 2..64.
- ADDR_W, 20, word address width; equals the mem request addr field width.
- DATA_W, 16, word width; equals the mem data field width.

Ports:
- clk  input  1  clock.
- rst  input  1  synchronous reset, active-low.
- req_valid  input  1  line request present.
- req_ready  output  1  block can accept a line request.
- req_rw  input  1  1 = writeback (write), 0 = fill (read).
- req_line_addr  input  ADDR_W-log2(WORDS_PER_LINE)  line-aligned address.
- req_wdata  input  WORDS_PER_LINE*DATA_W  writeback line; word i is bits [i*DATA_W +: DATA_W].
- done  output  1  one-cycle completion pulse.
- rdata  output  WORDS_PER_LINE*DATA_W  fill line, same packing as req_wdata.
- mem_req  output  cache_to_mem_type  fields used: valid, rw, addr[ADDR_W], data[DATA_W].
- mem_rsp  input  mem_to_cache_type  fields used: ready, data[DATA_W].

Behaviour:
- Clock and reset: single clock domain. Reset is synchronous, active-low (rst = 0 samples reset at posedge clk).
- Reset values: state IDLE, req_ready = 1, done = 0, rdata = 0, mem_req.valid = 0, mem_req.rw = 0, mem_req.addr = 0, mem_req.data = 0, word index = 0.
- Registered outputs: all mem_req fields, done and rdata.
- States: IDLE, XFER, DONE.
- IDLE:
  - req_ready = 1.
  - On req_valid = 1, latch req_rw, req_line_addr and req_wdata; set index = 0; go to XFER.
  - From the next cycle: mem_req.valid = 1, addr = {line_addr, 0}, data = word 0, rw = latched rw.
- XFER:
  - req_ready = 0. mem_req.valid stays 1.
  - addr, rw and data stay stable until mem_rsp.ready is sampled high (the controller samples them combinationally throughout).
  - On mem_rsp.ready = 1 for a read: capture mem_rsp.data into rdata word[index] in that cycle. mem_rsp.data is valid only while ready = 1.
  - On mem_rsp.ready = 1 with index < WORDS_PER_LINE-1: index += 1. The next cycle presents addr = {line_addr, index}, data = word[index], valid still 1 (back-to-back; the controller is in idle that cycle and starts the new word).
  - On mem_rsp.ready = 1 with index = WORDS_PER_LINE-1: go to DONE; mem_req.valid = 0 from the next cycle.
- DONE: done = 1 for exactly one cycle, req_ready = 0, then IDLE.
- rdata:
  - Holds the completed fill line until the next read request completes.
  - Writebacks never modify rdata.
  - Partially filled words are not guaranteed readable before done.
- Address arithmetic: word addr = line_addr concatenated with the log2(WORDS_PER_LINE)-bit index. Never crosses the line boundary; the index wraps only through a new request.
- mem_rsp.ready while not in XFER: ignored; no state or rdata change.
- req_valid while req_ready = 0: ignored; no queueing. The cache FSM must hold the request until accepted.
- Reset mid-transfer: the next edge forces IDLE with mem_req.valid = 0 and all outputs at reset values. The in-flight word is abandoned; the controller returns to idle after its own count.
- Latency: with a controller of rw_cycles = C and accept in cycle 0:
  - each word occupies C+1 cycles;
  - the last ready falls in cycle W*(C+1), where W = WORDS_PER_LINE;
  - done is high in cycle W*(C+1)+1;
  - req_ready returns to 1 in cycle W*(C+1)+2.
- Throughput: one line outstanding at most.

Test Plan:
- Reset then idle: rst = 0 for 2 cycles -> req_ready = 1, mem_req.valid = 0, done = 0, rdata = 0.
- Fill, W = 8, C = 2, line_addr = 0x1234:
  - mem model returns addr[15:0] ^ 0xA5A5;
  - mem_req.addr steps 0x91A0..0x91A7, one word per 3 cycles;
  - done in cycle 25 only;
  - rdata word i = (0x91A0+i) ^ 0xA5A5.
- Writeback, req_wdata words 0x0001..0x0008, line_addr = 0:
  - rw = 1 on all 8 transactions;
  - data/addr pairs (0,0x0001)..(7,0x0008), each stable until its ready;
  - rdata unchanged from prior fill.
- Back-to-back: second request held high during the first -> not accepted until req_ready = 1 in cycle W*(C+1)+2; second line completes correctly.
- Reset mid-transfer: rst = 0 after word 3 ready -> next cycle mem_req.valid = 0, state IDLE, no done pulse; a subsequent fill completes normally.
- Spurious ready: mem_rsp.ready = 1 with data 0xDEAD while IDLE -> no done, rdata unchanged.

Source files
------------

// File: rtl/line_mem_initiator.sv
// Line-to-word request sequencer between the cache FSM and the SRAM controller.
// One fill or writeback line is issued as WORDS_PER_LINE back-to-back word transfers.
package line_mem_pkg;
  typedef struct packed {
    logic        valid;
    logic        rw;
    logic [19:0] addr;
    logic [15:0] data;
  } cache_to_mem_type;

  typedef struct packed {
    logic        ready;
    logic [15:0] data;
  } mem_to_cache_type;
endpackage

module line_mem_initiator
  import line_mem_pkg::*;
#(
  parameter int WORDS_PER_LINE = 8,
  parameter int ADDR_W         = 20,
  parameter int DATA_W         = 16,
  localparam int IDX_W         = $clog2(WORDS_PER_LINE),
  localparam int LINE_W        = ADDR_W - IDX_W
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             req_valid,
  output logic                             req_ready,
  input  logic                             req_rw,
  input  logic [LINE_W-1:0]                req_line_addr,
  input  logic [WORDS_PER_LINE*DATA_W-1:0] req_wdata,
  output logic                             done,
  output logic [WORDS_PER_LINE*DATA_W-1:0] rdata,
  output cache_to_mem_type                 mem_req,
  input  mem_to_cache_type                 mem_rsp
);

  typedef enum logic [1:0] {
    IDLE,
    XFER,
    DONE
  } state_t;

  localparam logic [IDX_W-1:0] LAST = IDX_W'(WORDS_PER_LINE - 1);

  state_t            state;
  logic [IDX_W-1:0]  idx;
  logic [IDX_W-1:0]  nidx;
  logic [LINE_W-1:0] line_q;
  logic [DATA_W-1:0] wbuf [WORDS_PER_LINE];

  assign req_ready = (state == IDLE);
  assign nidx      = idx + IDX_W'(1);

  // Writeback line is kept locally so the cache FSM may change req_wdata
  always_ff @(posedge clk) begin
    if (state == IDLE && req_valid) begin
      for (int i = 0; i < WORDS_PER_LINE; i++) begin
        wbuf[i] <= req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= IDLE;
      idx     <= '0;
      line_q  <= '0;
      done    <= 1'b0;
      rdata   <= '0;
      mem_req <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            line_q        <= req_line_addr;
            idx           <= '0;
            state         <= XFER;
            mem_req.valid <= 1'b1;
            mem_req.rw    <= req_rw;
            mem_req.addr  <= {req_line_addr, IDX_W'(0)};
            mem_req.data  <= req_wdata[DATA_W-1:0];
          end
        end
        XFER: begin
          if (mem_rsp.ready) begin
            if (!mem_req.rw) begin
              for (int i = 0; i < WORDS_PER_LINE; i++) begin
                if (idx == IDX_W'(i)) begin
                  rdata[i*DATA_W +: DATA_W] <= mem_rsp.data;
                end
              end
            end
            if (idx == LAST) begin
              state         <= DONE;
              done          <= 1'b1;
              mem_req.valid <= 1'b0;
            end else begin
              idx          <= nidx;
              mem_req.addr <= {line_q, nidx};
              mem_req.data <= wbuf[nidx];
            end
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_line_mem_initiator.sv
// Bench for line_mem_initiator: word-level SRAM model plus scoreboards for
// word transactions and line-completion events.
module tb_line_mem_initiator;
  import line_mem_pkg::*;

  localparam int W  = 8;
  localparam int AW = 20;
  localparam int DW = 16;
  localparam int IW = 3;
  localparam int LW = AW - IW;
  localparam int C  = 2;
  localparam int LB = W * DW;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic          req_rw = 1'b0;
  logic [LW-1:0] req_line_addr = '0;
  logic [LB-1:0] req_wdata = '0;
  logic          done;
  logic [LB-1:0] rdata;
  cache_to_mem_type mem_req;
  mem_to_cache_type mem_rsp;

  line_mem_initiator #(
    .WORDS_PER_LINE(W),
    .ADDR_W(AW),
    .DATA_W(DW)
  ) dut (
    .clk(clk),
    .rst(rst),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_rw(req_rw),
    .req_line_addr(req_line_addr),
    .req_wdata(req_wdata),
    .done(done),
    .rdata(rdata),
    .mem_req(mem_req),
    .mem_rsp(mem_rsp)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic          rw;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
  } xact_t;

  typedef struct {
    int            cyc;
    logic [LB-1:0] line;
  } done_t;

  xact_t mq[$];
  done_t dq[$];
  xact_t e;
  done_t d;

  int   cnt = 0;
  int   rdy_cnt = 0;
  logic spur = 1'b0;
  logic prev_hold = 1'b0;
  cache_to_mem_type prev;

  initial mem_rsp = '0;

  // SRAM model with rw_cycles = C, plus monitor/scoreboard
  always @(negedge clk) begin
    mem_rsp.ready = 1'b0;
    mem_rsp.data  = '0;
    if (spur) begin
      mem_rsp.ready = 1'b1;
      mem_rsp.data  = 16'hDEAD;
    end else if (mem_req.valid === 1'b1) begin
      cnt++;
      if (cnt == C + 1) begin
        cnt = 0;
        mem_rsp.ready = 1'b1;
        mem_rsp.data  = mem_req.addr[15:0] ^ 16'hA5A5;
      end
    end else begin
      cnt = 0;
    end
    if (mem_req.valid === 1'b1 && prev_hold) begin
      checks++;
      if (mem_req !== prev) begin
        errors++;
        $display("FAIL req_stable: got %h want %h", mem_req, prev);
      end
    end
    prev      = mem_req;
    prev_hold = (mem_req.valid === 1'b1) && !mem_rsp.ready;
    if (mem_req.valid === 1'b1 && mem_rsp.ready && !spur) begin
      rdy_cnt++;
      checks++;
      if (mq.size() == 0) begin
        errors++;
        $display("FAIL xact_unexpected: got addr %h rw %b", mem_req.addr, mem_req.rw);
      end else begin
        e = mq.pop_front();
        if (mem_req.addr !== e.addr || mem_req.rw !== e.rw ||
            (e.rw && mem_req.data !== e.data)) begin
          errors++;
          $display("FAIL xact: got rw %b addr %h data %h want rw %b addr %h data %h",
                   mem_req.rw, mem_req.addr, mem_req.data, e.rw, e.addr, e.data);
        end
      end
    end
    if (done === 1'b1) begin
      checks++;
      if (dq.size() == 0) begin
        errors++;
        $display("FAIL done_unexpected: got done in cycle %0d want none", cyc);
      end else begin
        d = dq.pop_front();
        if (cyc != d.cyc) begin
          errors++;
          $display("FAIL done_cycle: got %0d want %0d", cyc, d.cyc);
        end
        checks++;
        if (rdata !== d.line) begin
          errors++;
          $display("FAIL done_rdata: got %h want %h", rdata, d.line);
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic chk(input string n, input logic [LB-1:0] got, input logic [LB-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h want %h", n, got, exp);
    end
  endtask

  function automatic logic [LB-1:0] fill_line(input logic [LW-1:0] la);
    logic [AW-1:0] a;
    logic [LB-1:0] l;
    l = '0;
    for (int i = 0; i < W; i++) begin
      a = {la, IW'(i)};
      l[i*DW +: DW] = a[15:0] ^ 16'hA5A5;
    end
    return l;
  endfunction

  task automatic push_line(input logic rw, input logic [LW-1:0] la,
                           input logic [LB-1:0] wd, input int n);
    xact_t x;
    for (int i = 0; i < n; i++) begin
      x.rw   = rw;
      x.addr = {la, IW'(i)};
      x.data = wd[i*DW +: DW];
      mq.push_back(x);
    end
  endtask

  task automatic push_done(input int t, input logic [LB-1:0] l);
    done_t x;
    x.cyc  = t;
    x.line = l;
    dq.push_back(x);
  endtask

  task automatic wait_ready();
    int k = 0;
    while (req_ready !== 1'b1 && k < 200) begin
      step();
      k++;
    end
    if (req_ready !== 1'b1) begin
      errors++;
      $display("FAIL req_ready_timeout: got %b want 1", req_ready);
    end
  endtask

  task automatic accept(input logic rw, input logic [LW-1:0] la,
                        input logic [LB-1:0] wd, output int t0);
    req_rw        = rw;
    req_line_addr = la;
    req_wdata     = wd;
    req_valid     = 1'b1;
    wait_ready();
    t0 = cyc;
    step();
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int k = 0;
    while ((mq.size() != 0 || dq.size() != 0 || req_ready !== 1'b1) && k < 400) begin
      step();
      k++;
    end
    checks++;
    if (mq.size() != 0 || dq.size() != 0) begin
      errors++;
      $display("FAIL idle_timeout: got %0d words %0d lines pending want 0", mq.size(), dq.size());
    end
  endtask

  localparam logic [LB-1:0] FILL_1234 =
    {16'h3402, 16'h3403, 16'h3400, 16'h3401, 16'h3406, 16'h3407, 16'h3404, 16'h3405};

  initial begin
    int t0;
    int ta;
    int tb;
    int r0;
    int k;
    logic [LB-1:0] last;
    logic [LB-1:0] wd;

    rst = 1'b0;
    step();
    step();
    chk("reset_req_ready", LB'(req_ready), LB'(1));
    chk("reset_mem_valid", LB'(mem_req.valid), LB'(0));
    chk("reset_mem_addr", LB'(mem_req.addr), LB'(0));
    chk("reset_done", LB'(done), LB'(0));
    chk("reset_rdata", rdata, '0);
    rst = 1'b1;
    step();

    push_line(1'b0, 17'h01234, '0, W);
    push_done(cyc + W * (C + 1) + 1, FILL_1234);
    accept(1'b0, 17'h01234, '0, t0);
    wait_idle();
    chk("fill_1234_rdata", rdata, FILL_1234);
    last = FILL_1234;

    wd = '0;
    for (int i = 0; i < W; i++) wd[i*DW +: DW] = DW'(i + 1);
    push_line(1'b1, 17'h00000, wd, W);
    push_done(cyc + W * (C + 1) + 1, last);
    accept(1'b1, 17'h00000, wd, t0);
    wait_idle();
    chk("wb_rdata_kept", rdata, last);

    spur = 1'b1;
    step();
    step();
    step();
    spur = 1'b0;
    step();
    step();
    chk("spur_rdata", rdata, last);
    chk("spur_done", LB'(done), LB'(0));
    chk("spur_req_ready", LB'(req_ready), LB'(1));

    push_line(1'b0, 17'h00042, '0, W);
    push_done(cyc + W * (C + 1) + 1, fill_line(17'h00042));
    req_rw        = 1'b0;
    req_line_addr = 17'h00042;
    req_valid     = 1'b1;
    wait_ready();
    ta = cyc;
    step();
    req_line_addr = 17'h000AB;
    push_line(1'b0, 17'h000AB, '0, W);
    chk("b2b_busy", LB'(req_ready), LB'(0));
    wait_ready();
    tb = cyc;
    chk("b2b_accept_cycle", LB'(tb), LB'(ta + W * (C + 1) + 2));
    push_done(tb + W * (C + 1) + 1, fill_line(17'h000AB));
    step();
    req_valid = 1'b0;
    wait_idle();
    chk("b2b_rdata", rdata, fill_line(17'h000AB));

    push_line(1'b0, 17'h00100, '0, 4);
    r0 = rdy_cnt;
    accept(1'b0, 17'h00100, '0, t0);
    k = 0;
    while (rdy_cnt < r0 + 4 && k < 200) begin
      step();
      k++;
    end
    chk("abort_words", LB'(rdy_cnt), LB'(r0 + 4));
    rst = 1'b0;
    step();
    chk("abort_mem_valid", LB'(mem_req.valid), LB'(0));
    chk("abort_done", LB'(done), LB'(0));
    chk("abort_req_ready", LB'(req_ready), LB'(1));
    chk("abort_rdata", rdata, '0);
    rst = 1'b1;
    step();
    step();

    push_line(1'b0, 17'h00ABC, '0, W);
    push_done(cyc + W * (C + 1) + 1, fill_line(17'h00ABC));
    accept(1'b0, 17'h00ABC, '0, t0);
    wait_idle();
    chk("refill_rdata", rdata, fill_line(17'h00ABC));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

endmodule
